// File: rtl/aes256_encrypt_core.sv
`timescale 1ns/1ps
// aes256_encrypt_core: iterative AES-256 encryptor, one round per clock, key schedule expanded on the fly.
// Define AES_CTR_EN to encrypt an internal counter block and XOR the result with the plaintext captured at accept.
module aes256_encrypt_core #(
  parameter int unsigned NR = 14,
  parameter int unsigned KW = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  plaintext,
  input  logic [KW-1:0] key_i,
  output logic          out_valid,
  input  logic          out_ready,
`ifdef AES_CTR_EN
  output logic [127:0]  ciphertext,
  input  logic          ctr_load,
  input  logic [127:0]  ctr_init
`else
  output logic [127:0]  ciphertext
`endif
);

  localparam logic [3:0] LAST = 4'(NR);

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777b_f26b6fc5_3001672b_fed7ab76, 128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115, 128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84, 128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8, 128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973, 128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479, 128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a, 128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df, 128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    return {s[127:120], s[87:80],   s[47:40],  s[7:0],
            s[95:88],   s[55:48],   s[15:8],   s[103:96],
            s[63:56],   s[23:16],   s[111:104], s[71:64],
            s[31:24],   s[119:112], s[79:72],  s[39:32]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      default: return 8'h00;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t         state, state_nxt;
  logic [127:0]   st, sb, sr, mc, rnd_out, blk_in, ct_nxt;
  logic [255:0]   kw;
  logic [3:0]     round_ctr;
  logic           accept, last_round;
  logic [31:0]    kt_in, kt_sub, kt;
  logic [31:0]    nxt0, nxt1, nxt2, nxt3;
`ifdef AES_CTR_EN
  logic [127:0]   ctr, ctr_use, pt_hold;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ROUND;
      ROUND:   if (last_round) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? ROUND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs of the FSM
  always_comb begin
    in_ready = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
  end

  assign accept     = in_valid & in_ready;
  assign last_round = (round_ctr == LAST);

  // Round datapath: 16 S-boxes on the state
  for (genvar g = 0; g < 16; g++) begin : g_sb
    assign sb[8*g +: 8] = sbox(st[8*g +: 8]);
  end
  assign sr      = shift_rows(sb);
  assign mc      = {mix_col(sr[127:96]), mix_col(sr[95:64]), mix_col(sr[63:32]), mix_col(sr[31:0])};
  assign rnd_out = (last_round ? sr : mc) ^ kw[127:0];

  // Key path: odd round index builds an even-numbered round key (RotWord + Rcon)
  assign kt_in = round_ctr[0] ? {kw[23:0], kw[31:24]} : kw[31:0];
  for (genvar g = 0; g < 4; g++) begin : g_ksb
    assign kt_sub[8*g +: 8] = sbox(kt_in[8*g +: 8]);
  end
  assign kt   = kt_sub ^ (round_ctr[0] ? {rcon((round_ctr + 4'd1) >> 1), 24'h0} : 32'h0);
  assign nxt0 = kw[255:224] ^ kt;
  assign nxt1 = kw[223:192] ^ nxt0;
  assign nxt2 = kw[191:160] ^ nxt1;
  assign nxt3 = kw[159:128] ^ nxt2;

`ifdef AES_CTR_EN
  assign ctr_use = ctr_load ? ctr_init : ctr;
  assign blk_in  = ctr_use;
  assign ct_nxt  = rnd_out ^ pt_hold;
`else
  assign blk_in  = plaintext;
  assign ct_nxt  = rnd_out;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= '0;
      kw         <= '0;
      round_ctr  <= '0;
      out_valid  <= 1'b0;
      ciphertext <= '0;
`ifdef AES_CTR_EN
      ctr        <= '0;
      pt_hold    <= '0;
`endif
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (accept) begin
        st        <= blk_in ^ key_i[KW-1:KW-128];
        kw        <= key_i;
        round_ctr <= 4'd1;
`ifdef AES_CTR_EN
        pt_hold   <= plaintext;
        ctr       <= {ctr_use[127:32], ctr_use[31:0] + 32'd1};
`endif
      end else if (state == ROUND) begin
        st <= rnd_out;
        kw <= {kw[127:0], nxt0, nxt1, nxt2, nxt3};
        if (last_round) begin
          round_ctr  <= '0;
          out_valid  <= 1'b1;
          ciphertext <= ct_nxt;
        end else begin
          round_ctr <= round_ctr + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes256_encrypt_core.sv
`timescale 1ns/1ps
// Directed bench for aes256_encrypt_core (ECB build): known-answer vectors, latency, backpressure, mid-round reset.
module tb_aes256_encrypt_core;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] plaintext = '0;
  logic [255:0] key_i = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] ciphertext;
`ifdef AES_CTR_EN
  logic         ctr_load = 1'b0;
  logic [127:0] ctr_init = '0;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [255:0] K_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] P_C3  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] C_ZRO = 128'hdc95c078a2408989ad48a21492842087;
  localparam logic [255:0] K_ECB = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] P_E1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C_E1  = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
  localparam logic [127:0] P_E2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C_E2  = 128'h591ccb10d410ed26dc5ba74a31362870;
  localparam logic [127:0] P_E3  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] C_E3  = 128'hb6ed21b99ca6f4f9f153e7b1beafed1d;
  localparam logic [127:0] P_E4  = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] C_E4  = 128'h23304b7a39f9f3ff067d8d8f9e24ecc7;

  aes256_encrypt_core #(.NR(14), .KW(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key_i      (key_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef AES_CTR_EN
    .ctr_load   (ctr_load),
    .ctr_init   (ctr_init),
`endif
    .ciphertext (ciphertext)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a block, wait (bounded) for acceptance, then scramble the inputs.
  task automatic send(input logic [255:0] k, input logic [127:0] p, input string tag);
    int n = 0;
    key_i = k; plaintext = p; in_valid = 1'b1;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " in_ready"}, {127'd0, in_ready}, 128'd1);
    @(negedge clk);
    in_valid = 1'b0; key_i = ~k; plaintext = ~p;
    check({tag, " busy"}, {127'd0, in_ready}, 128'd0);
  endtask

  task automatic wait_out(input string tag, input logic [127:0] exp);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 128'(lat), 128'd14);
    check({tag, " ct"}, ciphertext, exp);
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    check("rst out_valid", {127'd0, out_valid}, 128'd0);
    check("rst in_ready", {127'd0, in_ready}, 128'd0);
    check("rst ct", ciphertext, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle in_ready", {127'd0, in_ready}, 128'd1);

    // Known answers, back-to-back with key changes between blocks
    send(K_C3, P_C3, "c3");      wait_out("c3", C_C3);
    send(K_ECB, P_E1, "ecb1");   wait_out("ecb1", C_E1);
    send(K_ECB, P_E2, "ecb2");   wait_out("ecb2", C_E2);
    send('0, '0, "zero");        wait_out("zero", C_ZRO);
    send(K_C3, P_C3, "c3b");     wait_out("c3b", C_C3);
    send(K_ECB, P_E3, "ecb3");   wait_out("ecb3", C_E3);
    send(K_ECB, P_E4, "ecb4");   wait_out("ecb4", C_E4);
    @(negedge clk);
    check("drain out_valid", {127'd0, out_valid}, 128'd0);

    // Backpressure: result held, new block refused until released
    out_ready = 1'b0;
    send(K_C3, P_C3, "bp");
    wait_out("bp", C_C3);
    key_i = '0; plaintext = '0; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp hold out_valid", {127'd0, out_valid}, 128'd1);
      check("bp hold in_ready", {127'd0, in_ready}, 128'd0);
      check("bp hold ct", ciphertext, C_C3);
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", {127'd0, in_ready}, 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp accepted out_valid", {127'd0, out_valid}, 128'd0);
    check("bp accepted busy", {127'd0, in_ready}, 128'd0);
    wait_out("bp next", C_ZRO);

    // Reset during round 7 discards the block
    send(K_C3, P_C3, "mid");
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid rst out_valid", {127'd0, out_valid}, 128'd0);
    check("mid rst ct", ciphertext, 128'd0);
    check("mid rst in_ready", {127'd0, in_ready}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid no out_valid", 128'(seen), 128'd0);
    send(K_C3, P_C3, "post");
    wait_out("post", C_C3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
